// File: rtl/factor_pkg.sv
// factor_pkg
// Shared definitions for the factor search block: default operand widths,
// the search FSM state encoding and constants derived from the defaults.
// Ports: none (package only).
package factor_pkg;

    localparam int A_W_DEF = 4;
    localparam int B_W_DEF = 3;

    // Largest candidate values and the size of the candidate space when the
    // default widths are used (candidates start at 2, so 2^W-2 per axis).
    localparam int A_MAX  = (1 << A_W_DEF) - 1;
    localparam int B_MAX  = (1 << B_W_DEF) - 1;
    localparam int N_CAND = (A_MAX - 1) * (B_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/factor_search_seq_mult.sv
// seq_mult
// Shift-add multiplier that consumes one bit of b per step, LSB first.
// After B_W steps acc holds a*b.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears acc and the bit index
//   load  - clears acc and the bit index for a fresh product
//   step  - perform one shift-add step
//   a, b  - operands, must stay stable while stepping
//   acc   - running partial product (full width, cannot overflow)
//   last  - high while the final bit of b is being consumed
module seq_mult
    import factor_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
    output logic [A_W+B_W-1:0]   acc,
    output logic                 last
);

    localparam int PW = A_W + B_W;
    localparam int SW = (B_W > 1) ? $clog2(B_W) : 1;

    logic [SW-1:0] idx;
    logic [PW-1:0] a_ext;

    assign a_ext = {{B_W{1'b0}}, a};
    assign last  = (idx == SW'(B_W - 1));

    // Load has priority over stepping so the controller can clear the
    // accumulator in the same cycle it moves on to the next candidate.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            acc <= '0;
            idx <= '0;
        end else if (step) begin
            if (b[idx]) begin
                acc <= acc + (a_ext << idx);
            end
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: rtl/factor_search.sv
// factor_search
// Searches for the first pair (a, b), 2 <= a <= 2^A_W-1 and 2 <= b <= 2^B_W-1,
// with a*b == target. b is the outer loop, a the inner loop, both ascending.
// Each candidate costs B_W multiply cycles plus one compare cycle.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   start  - request a search, only honoured in IDLE
//   target - product to factor, captured when start is accepted
//   busy   - high while multiplying or comparing
//   done   - one-cycle pulse when the search ends
//   sat    - a factor pair was found (valid from done onward)
//   a_out  - found a, zero when sat=0
//   b_out  - found b, zero when sat=0
module factor_search
    import factor_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [A_W+B_W-1:0]   target,
    output logic                 busy,
    output logic                 done,
    output logic                 sat,
    output logic [A_W-1:0]       a_out,
    output logic [B_W-1:0]       b_out
);

    localparam logic [A_W-1:0] A_TOP = '1;
    localparam logic [B_W-1:0] B_TOP = '1;

    state_t               state;
    logic [A_W-1:0]       a_cnt;
    logic [B_W-1:0]       b_cnt;
    logic [A_W+B_W-1:0]   target_q;
    logic [A_W+B_W-1:0]   acc;
    logic                 last;

    // The multiplier only advances in MUL; in every other state it is held
    // cleared, which also gives it a fresh start for each new candidate.
    seq_mult #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_mult (
        .clk  (clk),
        .rst  (rst),
        .load (state != MUL),
        .step (state == MUL),
        .a    (a_cnt),
        .b    (b_cnt),
        .acc  (acc),
        .last (last)
    );

    // Search controller: candidate counters, captured target and all
    // outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sat      <= 1'b0;
            a_out    <= '0;
            b_out    <= '0;
            a_cnt    <= A_W'(2);
            b_cnt    <= B_W'(2);
            target_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        target_q <= target;
                        a_cnt    <= A_W'(2);
                        b_cnt    <= B_W'(2);
                        sat      <= 1'b0;
                        a_out    <= '0;
                        b_out    <= '0;
                        busy     <= 1'b1;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    if (last) begin
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (acc == target_q) begin
                        sat   <= 1'b1;
                        a_out <= a_cnt;
                        b_out <= b_cnt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (a_cnt != A_TOP) begin
                        a_cnt <= a_cnt + 1'b1;
                        state <= MUL;
                    end else if (b_cnt != B_TOP) begin
                        a_cnt <= A_W'(2);
                        b_cnt <= b_cnt + 1'b1;
                        state <= MUL;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_factor_search.sv
// tb_factor_search
// Directed-vector bench for factor_search with default widths. Each vector
// gives a target and the hand-computed done latency and result; a few
// hand-written sequences cover reset mid-search and start/target changes
// while busy.
module tb_factor_search;

    logic       clk;
    logic       rst;
    logic       start;
    logic [6:0] target;
    logic       busy;
    logic       done;
    logic       sat;
    logic [3:0] a_out;
    logic [2:0] b_out;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [6:0] target;
        int         cycles;
        logic       sat;
        logic [3:0] a;
        logic [2:0] b;
    } vec_t;

    vec_t vecs[8];

    factor_search dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .target (target),
        .busy   (busy),
        .done   (done),
        .sat    (sat),
        .a_out  (a_out),
        .b_out  (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records one comparison and reports it if the values differ.
    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Presents start with the given target for one edge, then counts edges
    // (the accepting edge is edge 1) until done is seen or the bound expires.
    // Also checks that the accepting edge raised busy and cleared the result.
    task automatic applyStimulus(input logic [6:0] t, output int cycles, output logic found);
        @(negedge clk);
        target = t;
        start  = 1'b1;
        cycles = 0;
        found  = 1'b0;
        while (!found && cycles < 1000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = 1'b0;
            if (cycles == 1) begin
                checkOutput("busy_after_accept", busy, 1);
                checkOutput("sat_cleared_on_start", sat, 0);
                checkOutput("a_cleared_on_start", a_out, 0);
            end
            if (done) found = 1'b1;
        end
        if (!found) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL done_timeout: got no done, expected done within 1000 cycles");
        end
    endtask

    initial begin
        int   cycles;
        logic found;
        int   doneCount;
        int   doneAt;

        vecs[0] = '{7'd21,  81,  1'b1, 4'd7,  3'd3};
        vecs[1] = '{7'd4,   5,   1'b1, 4'd2,  3'd2};
        vecs[2] = '{7'd105, 337, 1'b1, 4'd15, 3'd7};
        vecs[3] = '{7'd13,  337, 1'b0, 4'd0,  3'd0};
        vecs[4] = '{7'd1,   337, 1'b0, 4'd0,  3'd0};
        vecs[5] = '{7'd6,   9,   1'b1, 4'd3,  3'd2};
        vecs[6] = '{7'd98,  333, 1'b1, 4'd14, 3'd7};
        vecs[7] = '{7'd0,   337, 1'b0, 4'd0,  3'd0};

        rst    = 1'b1;
        start  = 1'b0;
        target = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_sat",  sat,  0);
        checkOutput("reset_a",    a_out, 0);
        checkOutput("reset_b",    b_out, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].target, cycles, found);
            if (found) begin
                checkOutput($sformatf("v%0d_cycles", i), cycles, vecs[i].cycles);
                checkOutput($sformatf("v%0d_sat", i), sat, vecs[i].sat);
                checkOutput($sformatf("v%0d_a", i), a_out, vecs[i].a);
                checkOutput($sformatf("v%0d_b", i), b_out, vecs[i].b);
                checkOutput($sformatf("v%0d_busy_at_done", i), busy, 0);
                repeat (3) @(negedge clk);
                checkOutput($sformatf("v%0d_done_pulse", i), done, 0);
                checkOutput($sformatf("v%0d_sat_hold", i), sat, vecs[i].sat);
                checkOutput($sformatf("v%0d_a_hold", i), a_out, vecs[i].a);
            end
        end

        // Reset in the middle of a target=21 search: no done may follow.
        @(negedge clk);
        target = 7'd21;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_sat", sat, 0);
        doneCount = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("midrst_no_done", doneCount, 0);

        // Start presented together with reset is dropped.
        target = 7'd4;
        start  = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        checkOutput("start_with_rst_busy", busy, 0);

        applyStimulus(7'd21, cycles, found);
        if (found) begin
            checkOutput("after_rst_cycles", cycles, 81);
            checkOutput("after_rst_a", a_out, 7);
            checkOutput("after_rst_b", b_out, 3);
        end

        // Start re-pulsed with a new target while busy: the original target
        // wins and exactly one done pulse appears, 81 edges after the start.
        @(negedge clk);
        target = 7'd21;
        start  = 1'b1;
        doneCount = 0;
        doneAt    = 0;
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (c == 10 || c == 40) begin
                target = 7'd4;
                start  = 1'b1;
            end
            if (c == 11 || c == 41) target = 7'd6;
            if (done) begin
                doneCount++;
                doneAt = c;
            end
        end
        checkOutput("busy_restart_done_count", doneCount, 1);
        checkOutput("busy_restart_done_at", doneAt, 81);
        checkOutput("busy_restart_sat", sat, 1);
        checkOutput("busy_restart_a", a_out, 7);
        checkOutput("busy_restart_b", b_out, 3);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
